// File: rtl/branch_flag_unit.sv
// Branch/flag unit: registers ALU condition flags and mult hi/lo, resolves conditional
// branches, and issues a one-cycle PC redirect followed by a counted pipeline flush.
module branch_flag_unit #(
  parameter int unsigned OFS_W        = 16,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  // ALU status interface
  input  logic             alu_valid,
  input  logic [6:0]       alu_op,
  input  logic             zflag,
  input  logic             carryflag,
  input  logic             signflag,
  input  logic             overflowflag,
  input  logic [31:0]      hi_value,
  input  logic [31:0]      lo_value,
  // Branch request
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [3:0]       br_cond,
  input  logic [31:0]      br_pc,
  input  logic [OFS_W-1:0] br_offset,
  // Registered state and redirect
  output logic [3:0]       flags_q,
  output logic [31:0]      hi_q,
  output logic [31:0]      lo_q,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             illegal_br
);

  localparam logic [6:0] OpMult  = 7'b0000010;
  localparam logic [6:0] OpMultu = 7'b0000001;
  localparam logic [2:0] CntInit = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  flags_d;
  logic [31:0] hi_d, lo_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        flush_q, flush_d;
  logic        illegal_q, illegal_d;

  logic        in_idle;
  logic        flag_op;
  logic        mult_op;
  logic [3:0]  alu_flags;
  logic [3:0]  cond_flags;
  logic        cond_z, cond_c, cond_s, cond_v;
  logic        cond_legal;
  logic        cond_met;
  logic        take;
  logic [31:0] ofs_ext;
  logic [31:0] target;

  assign in_idle   = (state_q == StIdle);
  assign flag_op   = (alu_op[6:4] == 3'b000) || (alu_op[6:4] == 3'b001) ||
                     (alu_op[6:4] == 3'b010);
  assign mult_op   = (alu_op == OpMult) || (alu_op == OpMultu);
  assign alu_flags = {overflowflag, signflag, carryflag, zflag};

  // A flag-updating op in the same cycle as the branch is forwarded to the compare.
  assign cond_flags = (alu_valid && br_valid && flag_op) ? alu_flags : flags_q;
  assign cond_z     = cond_flags[0];
  assign cond_c     = cond_flags[1];
  assign cond_s     = cond_flags[2];
  assign cond_v     = cond_flags[3];

  always_comb begin
    cond_met   = 1'b0;
    cond_legal = 1'b1;
    unique case (br_cond)
      4'b0000: cond_met = 1'b1;
      4'b0001: cond_met = cond_z;
      4'b0010: cond_met = ~cond_z;
      4'b0011: cond_met = cond_c;
      4'b0100: cond_met = ~cond_c;
      4'b0101: cond_met = cond_s;
      4'b0110: cond_met = ~cond_s;
      4'b0111: cond_met = cond_v;
      4'b1000: cond_met = ~cond_v;
      4'b1001: cond_met = cond_s ^ cond_v;
      default: cond_legal = 1'b0;
    endcase
  end

  assign ofs_ext = 32'(signed'(br_offset));
  assign target  = br_pc + ofs_ext;
  assign take    = in_idle && br_valid && cond_legal && cond_met;

  // Next-state and registered-output logic.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    flags_d          = flags_q;
    hi_d             = hi_q;
    lo_d             = lo_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    illegal_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (alu_valid && flag_op) begin
          flags_d = alu_flags;
        end
        if (alu_valid && mult_op) begin
          hi_d = hi_value;
          lo_d = lo_value;
        end
        if (br_valid && !cond_legal) begin
          illegal_d = 1'b1;
        end
        if (take) begin
          redirect_valid_d = 1'b1;
          redirect_pc_d    = target;
          cnt_d            = CntInit;
          state_d          = StFlush;
        end
      end
      StFlush: begin
        // Squashed instructions and branches are ignored until the count runs out.
        if (cnt_q == 3'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 3'd0;
      end
    endcase

    flush_d = (state_d == StFlush);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      cnt_q            <= 3'd0;
      flags_q          <= 4'd0;
      hi_q             <= 32'd0;
      lo_q             <= 32'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      flush_q          <= 1'b0;
      illegal_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      flags_q          <= flags_d;
      hi_q             <= hi_d;
      lo_q             <= lo_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      illegal_q        <= illegal_d;
    end
  end

  assign br_ready       = in_idle;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign illegal_br     = illegal_q;

endmodule
